// File: rtl/lc3_ctrl_pkg.sv
// eLC-3 control unit shared types: state encoding, opcodes and
// datapath mux / ALU function encodings.
package lc3_ctrl_pkg;

    typedef enum logic [4:0] {
        S_HALTED = 5'd0,
        S_FETCH1,
        S_FETCH2,
        S_FETCH3,
        S_DECODE,
        S_ADD,
        S_AND,
        S_NOT,
        S_BR_T,
        S_JMP,
        S_JSR1,
        S_JSR2,
        S_LDR1,
        S_LDR2,
        S_LDR3,
        S_STR1,
        S_STR2,
        S_STR3,
        S_PAUSE1,
        S_PAUSE2,
        S_ERROR
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_PC1  = 2'd0;
    localparam logic [1:0] PCMUX_ADDR = 2'd2;

    localparam logic ADDR1_PC  = 1'b0;
    localparam logic ADDR1_SR1 = 1'b1;

    localparam logic [1:0] ADDR2_ZERO  = 2'd0;
    localparam logic [1:0] ADDR2_OFF6  = 2'd1;
    localparam logic [1:0] ADDR2_OFF9  = 2'd2;
    localparam logic [1:0] ADDR2_OFF11 = 2'd3;

    localparam logic [1:0] DRMUX_IR = 2'd0;
    localparam logic [1:0] DRMUX_R7 = 2'd1;

    localparam logic [1:0] SR1MUX_IR119 = 2'd0;
    localparam logic [1:0] SR1MUX_IR86  = 2'd1;

    localparam logic SR2MUX_SR2  = 1'b0;
    localparam logic SR2MUX_IMM5 = 1'b1;

    localparam logic MARMUX_ZEXT8 = 1'b0;
    localparam logic MARMUX_ADDR  = 1'b1;

    localparam logic [1:0] ALUK_ADD   = 2'd0;
    localparam logic [1:0] ALUK_AND   = 2'd1;
    localparam logic [1:0] ALUK_NOT   = 2'd2;
    localparam logic [1:0] ALUK_PASSA = 2'd3;

    function automatic logic is_mem_wait(state_t s);
        return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR3);
    endfunction

endpackage

// File: rtl/lc3_control_fsm_if.sv
// RAM request/ready handshake between the control unit and memory.
interface lc3_control_fsm_if;
    logic Mem_Req;
    logic Mem_WE;
    logic Mem_Ready;

    modport master (output Mem_Req, output Mem_WE, input Mem_Ready);
    modport slave  (input Mem_Req, input Mem_WE, output Mem_Ready);
endinterface

// File: rtl/mem_wait_timer.sv
// Counts RAM wait cycles; expired flags the cycle that would reach
// MEM_TIMEOUT. MEM_TIMEOUT of 0 never expires.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && en && (cnt_q == LAST);
endmodule

// File: rtl/lc3_control_fsm.sv
// Multi-cycle eLC-3 control unit: sequences fetch/decode/execute
// and drives every datapath control plus the RAM handshake.
module lc3_control_fsm
    import lc3_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] IR_15_12,
    input  logic       IR_5,
    input  logic       BEN,
    lc3_control_fsm_if.master mem,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_REG,
    output logic       LD_CC,
    output logic       LD_PC,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic       ADDR1MUX,
    output logic       SR2MUX,
    output logic       MARMUX,
    output logic       MIO_EN,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] PCMUX,
    output logic [1:0] DRMUX,
    output logic [1:0] SR1MUX,
    output logic [1:0] ALUK,
    output logic       Err,
    output logic [4:0] State_Out
);
    state_t state_q, state_d, done_st;
    logic   in_wait, tmr_expired;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_HALTED;
        end else begin
            state_q <= state_d;
        end
    end

    // Wait states are never adjacent, so leaving one always clears the timer.
    assign in_wait = is_mem_wait(state_q);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk     (Clk),
        .rst_n   (Reset),
        .clr     (!in_wait),
        .en      (in_wait && !mem.Mem_Ready),
        .expired (tmr_expired)
    );

    assign done_st   = Run ? S_FETCH1 : S_HALTED;
    assign State_Out = state_q;

    always_comb begin
        state_d     = state_q;
        mem.Mem_Req = 1'b0;
        mem.Mem_WE  = 1'b0;
        LD_MAR      = 1'b0;
        LD_MDR      = 1'b0;
        LD_IR       = 1'b0;
        LD_BEN      = 1'b0;
        LD_REG      = 1'b0;
        LD_CC       = 1'b0;
        LD_PC       = 1'b0;
        GatePC      = 1'b0;
        GateMDR     = 1'b0;
        GateALU     = 1'b0;
        GateMARMUX  = 1'b0;
        ADDR1MUX    = ADDR1_PC;
        SR2MUX      = SR2MUX_SR2;
        MARMUX      = MARMUX_ZEXT8;
        MIO_EN      = 1'b0;
        ADDR2MUX    = ADDR2_ZERO;
        PCMUX       = PCMUX_PC1;
        DRMUX       = DRMUX_IR;
        SR1MUX      = SR1MUX_IR119;
        ALUK        = ALUK_ADD;
        Err         = 1'b0;

        unique case (state_q)
            S_HALTED: if (Run) state_d = S_FETCH1;
            S_FETCH1: begin
                GatePC  = 1'b1;
                LD_MAR  = 1'b1;
                LD_PC   = 1'b1;
                PCMUX   = PCMUX_PC1;
                state_d = S_FETCH2;
            end
            S_FETCH2, S_LDR2: begin
                mem.Mem_Req = 1'b1;
                MIO_EN      = 1'b1;
                LD_MDR      = mem.Mem_Ready;
                if (mem.Mem_Ready) begin
                    state_d = (state_q == S_FETCH2) ? S_FETCH3 : S_LDR3;
                end else if (tmr_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_FETCH3: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                LD_BEN = 1'b1;
                unique case (IR_15_12)
                    OP_ADD:   state_d = S_ADD;
                    OP_AND:   state_d = S_AND;
                    OP_NOT:   state_d = S_NOT;
                    OP_BR:    state_d = BEN ? S_BR_T : done_st;
                    OP_JMP:   state_d = S_JMP;
                    OP_JSR:   state_d = S_JSR1;
                    OP_LDR:   state_d = S_LDR1;
                    OP_STR:   state_d = S_STR1;
                    OP_PAUSE: state_d = S_PAUSE1;
                    default:  state_d = done_st;
                endcase
            end
            S_ADD, S_AND, S_NOT: begin
                SR1MUX  = SR1MUX_IR86;
                SR2MUX  = IR_5 ? SR2MUX_IMM5 : SR2MUX_SR2;
                ALUK    = (state_q == S_AND) ? ALUK_AND :
                          (state_q == S_NOT) ? ALUK_NOT : ALUK_ADD;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_d = done_st;
            end
            S_BR_T: begin
                ADDR1MUX = ADDR1_PC;
                ADDR2MUX = ADDR2_OFF9;
                PCMUX    = PCMUX_ADDR;
                LD_PC    = 1'b1;
                state_d  = done_st;
            end
            S_JMP: begin
                SR1MUX   = SR1MUX_IR86;
                ADDR1MUX = ADDR1_SR1;
                ADDR2MUX = ADDR2_ZERO;
                PCMUX    = PCMUX_ADDR;
                LD_PC    = 1'b1;
                state_d  = done_st;
            end
            S_JSR1: begin
                GatePC  = 1'b1;
                DRMUX   = DRMUX_R7;
                LD_REG  = 1'b1;
                state_d = S_JSR2;
            end
            S_JSR2: begin
                ADDR1MUX = ADDR1_PC;
                ADDR2MUX = ADDR2_OFF11;
                PCMUX    = PCMUX_ADDR;
                LD_PC    = 1'b1;
                state_d  = done_st;
            end
            S_LDR1, S_STR1: begin
                SR1MUX     = SR1MUX_IR86;
                ADDR1MUX   = ADDR1_SR1;
                ADDR2MUX   = ADDR2_OFF6;
                MARMUX     = MARMUX_ADDR;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                state_d    = (state_q == S_LDR1) ? S_LDR2 : S_STR2;
            end
            S_LDR3: begin
                GateMDR = 1'b1;
                DRMUX   = DRMUX_IR;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_d = done_st;
            end
            S_STR2: begin
                SR1MUX  = SR1MUX_IR119;
                ALUK    = ALUK_PASSA;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
                state_d = S_STR3;
            end
            S_STR3: begin
                mem.Mem_Req = 1'b1;
                mem.Mem_WE  = 1'b1;
                if (mem.Mem_Ready) begin
                    state_d = done_st;
                end else if (tmr_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_PAUSE1: if (Continue) state_d = S_PAUSE2;
            S_PAUSE2: if (!Continue) state_d = done_st;
            S_ERROR:  Err = 1'b1;
            default:  state_d = S_HALTED;
        endcase
    end
endmodule

// File: tb/tb_lc3_control_fsm.sv
// Scoreboarded bench for lc3_control_fsm: per-cycle expected state
// and control word queued with stimulus, compared as cycles retire.
module tb_lc3_control_fsm;
    import lc3_ctrl_pkg::*;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc;
        logic       g_pc, g_mdr, g_alu, g_marmux;
        logic       a1, sr2, marmux, mio;
        logic [1:0] a2, pcm, drm, sr1, aluk;
        logic       req, we, err;
    } ctl_t;

    typedef struct packed {
        logic [4:0] st;
        ctl_t       c;
    } exp_t;

    typedef struct packed {
        logic       run, cont, rdy, ben, ir5;
        logic [3:0] op;
    } stim_t;

    localparam ctl_t C0    = '0;
    localparam ctl_t CF1   = '{ld_mar: 1'b1, ld_pc: 1'b1, g_pc: 1'b1,
                               default: '0};
    localparam ctl_t CF2   = '{req: 1'b1, mio: 1'b1, default: '0};
    localparam ctl_t CF2R  = '{req: 1'b1, mio: 1'b1, ld_mdr: 1'b1,
                               default: '0};
    localparam ctl_t CF3   = '{ld_ir: 1'b1, g_mdr: 1'b1, default: '0};
    localparam ctl_t CDEC  = '{ld_ben: 1'b1, default: '0};
    localparam ctl_t CALU  = '{sr1: 2'd1, g_alu: 1'b1, ld_reg: 1'b1,
                               ld_cc: 1'b1, default: '0};
    localparam ctl_t CBRT  = '{ld_pc: 1'b1, pcm: 2'd2, a2: 2'd2,
                               default: '0};
    localparam ctl_t CJMP  = '{ld_pc: 1'b1, pcm: 2'd2, sr1: 2'd1,
                               a1: 1'b1, default: '0};
    localparam ctl_t CJSR1 = '{g_pc: 1'b1, drm: 2'd1, ld_reg: 1'b1,
                               default: '0};
    localparam ctl_t CJSR2 = '{ld_pc: 1'b1, pcm: 2'd2, a2: 2'd3,
                               default: '0};
    localparam ctl_t CMEMA = '{sr1: 2'd1, a1: 1'b1, a2: 2'd1,
                               marmux: 1'b1, g_marmux: 1'b1,
                               ld_mar: 1'b1, default: '0};
    localparam ctl_t CLDR3 = '{g_mdr: 1'b1, ld_reg: 1'b1, ld_cc: 1'b1,
                               default: '0};
    localparam ctl_t CSTR2 = '{aluk: 2'd3, g_alu: 1'b1, ld_mdr: 1'b1,
                               default: '0};
    localparam ctl_t CSTR3 = '{req: 1'b1, we: 1'b1, default: '0};
    localparam ctl_t CERR  = '{err: 1'b1, default: '0};

    logic       Clk = 1'b0;
    logic       Reset, Run, Continue, IR_5, BEN;
    logic [3:0] IR_15_12;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic       ADDR1MUX, SR2MUX, MARMUX, MIO_EN, Err;
    logic [1:0] ADDR2MUX, PCMUX, DRMUX, SR1MUX, ALUK;
    logic [4:0] State_Out;

    int    n_cmp  = 0;
    int    n_fail = 0;
    stim_t sq[$];
    exp_t  sb[$];

    lc3_control_fsm_if mem_if ();

    lc3_control_fsm #(
        .MEM_TIMEOUT(4)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Run        (Run),
        .Continue   (Continue),
        .IR_15_12   (IR_15_12),
        .IR_5       (IR_5),
        .BEN        (BEN),
        .mem        (mem_if),
        .LD_MAR     (LD_MAR),
        .LD_MDR     (LD_MDR),
        .LD_IR      (LD_IR),
        .LD_BEN     (LD_BEN),
        .LD_REG     (LD_REG),
        .LD_CC      (LD_CC),
        .LD_PC      (LD_PC),
        .GatePC     (GatePC),
        .GateMDR    (GateMDR),
        .GateALU    (GateALU),
        .GateMARMUX (GateMARMUX),
        .ADDR1MUX   (ADDR1MUX),
        .SR2MUX     (SR2MUX),
        .MARMUX     (MARMUX),
        .MIO_EN     (MIO_EN),
        .ADDR2MUX   (ADDR2MUX),
        .PCMUX      (PCMUX),
        .DRMUX      (DRMUX),
        .SR1MUX     (SR1MUX),
        .ALUK       (ALUK),
        .Err        (Err),
        .State_Out  (State_Out)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        #3;
        if (Reset === 1'b1) begin
            n_cmp++;
            if (!$onehot0({GatePC, GateMDR, GateALU, GateMARMUX})) begin
                n_fail++;
                $display("FAIL bus_gates got %b want onehot0",
                         {GatePC, GateMDR, GateALU, GateMARMUX});
            end
        end
    end

    function automatic exp_t obs();
        exp_t o;
        o.st         = State_Out;
        o.c.ld_mar   = LD_MAR;
        o.c.ld_mdr   = LD_MDR;
        o.c.ld_ir    = LD_IR;
        o.c.ld_ben   = LD_BEN;
        o.c.ld_reg   = LD_REG;
        o.c.ld_cc    = LD_CC;
        o.c.ld_pc    = LD_PC;
        o.c.g_pc     = GatePC;
        o.c.g_mdr    = GateMDR;
        o.c.g_alu    = GateALU;
        o.c.g_marmux = GateMARMUX;
        o.c.a1       = ADDR1MUX;
        o.c.sr2      = SR2MUX;
        o.c.marmux   = MARMUX;
        o.c.mio      = MIO_EN;
        o.c.a2       = ADDR2MUX;
        o.c.pcm      = PCMUX;
        o.c.drm      = DRMUX;
        o.c.sr1      = SR1MUX;
        o.c.aluk     = ALUK;
        o.c.req      = mem_if.Mem_Req;
        o.c.we       = mem_if.Mem_WE;
        o.c.err      = Err;
        return o;
    endfunction

    function automatic stim_t sx(logic [3:0] op, logic run, logic rdy,
                                 logic ben = 1'b0, logic cont = 1'b0,
                                 logic ir5 = 1'b0);
        stim_t s;
        s.op = op; s.run = run; s.rdy = rdy;
        s.ben = ben; s.cont = cont; s.ir5 = ir5;
        return s;
    endfunction

    task automatic add(input stim_t s, input state_t st, input ctl_t c);
        exp_t e;
        e.st = st;
        e.c  = c;
        sq.push_back(s);
        sb.push_back(e);
    endtask

    task automatic apply(input stim_t s);
        @(negedge Clk);
        Run              = s.run;
        Continue         = s.cont;
        mem_if.Mem_Ready = s.rdy;
        BEN              = s.ben;
        IR_5             = s.ir5;
        IR_15_12         = s.op;
        #1;
    endtask

    task automatic fet(input logic [3:0] op, input logic ir5);
        add(sx(op, 1'b0, 1'b1, 1'b0, 1'b0, ir5), S_FETCH1, CF1);
        add(sx(op, 1'b0, 1'b1, 1'b0, 1'b0, ir5), S_FETCH2, CF2R);
        add(sx(op, 1'b0, 1'b1, 1'b0, 1'b0, ir5), S_FETCH3, CF3);
    endtask

    task automatic test_reset();
        exp_t e, o;
        @(negedge Clk); #1;
        e = '0; o = obs(); n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_init got %0d/%h want %0d/%h",
                     o.st, o.c, e.st, e.c);
        end
        @(negedge Clk); Reset = 1'b1;
        add(sx(OP_ADD, 1'b1, 1'b0), S_HALTED, C0);
        add(sx(OP_ADD, 1'b0, 1'b0), S_FETCH1, CF1);
        add(sx(OP_ADD, 1'b0, 1'b0), S_FETCH2, CF2);
        while (sq.size() != 0) begin
            apply(sq.pop_front());
            e = sb.pop_front(); o = obs(); n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_seq got %0d/%h want %0d/%h",
                         o.st, o.c, e.st, e.c);
            end
        end
        #2; Reset = 1'b0; Run = 1'b0; #1;
        e = '0; o = obs(); n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_async got %0d/%h want %0d/%h",
                     o.st, o.c, e.st, e.c);
        end
        @(negedge Clk); #1;
        o = obs(); n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_hold got %0d/%h want %0d/%h",
                     o.st, o.c, e.st, e.c);
        end
        Reset = 1'b1;
    endtask

    task automatic test_alu();
        exp_t       e, o;
        ctl_t       c;
        logic [3:0] op;
        logic       i5;
        state_t     st;
        for (int i = 0; i < 3; i++) begin
            op = (i == 0) ? OP_ADD : (i == 1) ? OP_AND : OP_NOT;
            st = (i == 0) ? S_ADD : (i == 1) ? S_AND : S_NOT;
            i5 = (i != 1);
            c = CALU;
            c.sr2 = i5;
            c.aluk = 2'(i);
            add(sx(op, 1'b1, 1'b1, 1'b0, 1'b0, i5), S_HALTED, C0);
            fet(op, i5);
            add(sx(op, 1'b0, 1'b1, 1'b0, 1'b0, i5), S_DECODE, CDEC);
            add(sx(op, 1'b0, 1'b1, 1'b0, 1'b0, i5), st, c);
        end
        while (sq.size() != 0) begin
            apply(sq.pop_front());
            e = sb.pop_front(); o = obs(); n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL alu_seq got %0d/%h want %0d/%h",
                         o.st, o.c, e.st, e.c);
            end
        end
    endtask

    task automatic test_ldr_wait();
        exp_t e, o;
        add(sx(OP_LDR, 1'b1, 1'b0), S_HALTED, C0);
        fet(OP_LDR, 1'b0);
        add(sx(OP_LDR, 1'b0, 1'b1), S_DECODE, CDEC);
        add(sx(OP_LDR, 1'b0, 1'b1), S_LDR1, CMEMA);
        for (int i = 0; i < 3; i++)
            add(sx(OP_LDR, 1'b0, 1'b0), S_LDR2, CF2);
        add(sx(OP_LDR, 1'b0, 1'b1), S_LDR2, CF2R);
        add(sx(OP_LDR, 1'b0, 1'b0), S_LDR3, CLDR3);
        while (sq.size() != 0) begin
            apply(sq.pop_front());
            e = sb.pop_front(); o = obs(); n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL ldr_seq got %0d/%h want %0d/%h",
                         o.st, o.c, e.st, e.c);
            end
        end
    endtask

    task automatic test_branch_jump();
        exp_t e, o;
        add(sx(OP_BR, 1'b1, 1'b0), S_HALTED, C0);
        fet(OP_BR, 1'b0);
        add(sx(OP_BR, 1'b0, 1'b0, 1'b0), S_DECODE, CDEC);
        add(sx(OP_BR, 1'b1, 1'b0), S_HALTED, C0);
        fet(OP_BR, 1'b0);
        add(sx(OP_BR, 1'b0, 1'b0, 1'b1), S_DECODE, CDEC);
        add(sx(OP_BR, 1'b0, 1'b0), S_BR_T, CBRT);
        add(sx(OP_JMP, 1'b1, 1'b0), S_HALTED, C0);
        fet(OP_JMP, 1'b0);
        add(sx(OP_JMP, 1'b0, 1'b0), S_DECODE, CDEC);
        add(sx(OP_JMP, 1'b0, 1'b0), S_JMP, CJMP);
        add(sx(OP_JSR, 1'b1, 1'b0), S_HALTED, C0);
        fet(OP_JSR, 1'b0);
        add(sx(OP_JSR, 1'b0, 1'b0), S_DECODE, CDEC);
        add(sx(OP_JSR, 1'b0, 1'b0), S_JSR1, CJSR1);
        add(sx(OP_JSR, 1'b0, 1'b0), S_JSR2, CJSR2);
        while (sq.size() != 0) begin
            apply(sq.pop_front());
            e = sb.pop_front(); o = obs(); n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL branch_seq got %0d/%h want %0d/%h",
                         o.st, o.c, e.st, e.c);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, o;
        add(sx(OP_ADD, 1'b1, 1'b1), S_HALTED, C0);
        fet(OP_ADD, 1'b1);
        add(sx(OP_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), S_DECODE, CDEC);
        add(sx(OP_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1), S_ADD,
            '{sr1: 2'd1, sr2: 1'b1, g_alu: 1'b1, ld_reg: 1'b1,
              ld_cc: 1'b1, default: '0});
        fet(4'hF, 1'b0);
        add(sx(4'hF, 1'b0, 1'b1), S_DECODE, CDEC);
        while (sq.size() != 0) begin
            apply(sq.pop_front());
            e = sb.pop_front(); o = obs(); n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b_seq got %0d/%h want %0d/%h",
                         o.st, o.c, e.st, e.c);
            end
        end
    endtask

    task automatic test_pause();
        exp_t e, o;
        add(sx(OP_PAUSE, 1'b1, 1'b1), S_HALTED, C0);
        fet(OP_PAUSE, 1'b0);
        add(sx(OP_PAUSE, 1'b0, 1'b1), S_DECODE, CDEC);
        for (int i = 0; i < 3; i++)
            add(sx(OP_PAUSE, 1'b1, 1'b1, 1'b0, 1'b0), S_PAUSE1, C0);
        add(sx(OP_PAUSE, 1'b0, 1'b1, 1'b0, 1'b1), S_PAUSE1, C0);
        add(sx(OP_PAUSE, 1'b0, 1'b1, 1'b0, 1'b1), S_PAUSE2, C0);
        add(sx(OP_PAUSE, 1'b1, 1'b1, 1'b0, 1'b0), S_PAUSE2, C0);
        fet(OP_PAUSE, 1'b0);
        add(sx(OP_PAUSE, 1'b0, 1'b1), S_DECODE, CDEC);
        add(sx(OP_PAUSE, 1'b0, 1'b1, 1'b0, 1'b1), S_PAUSE1, C0);
        add(sx(OP_PAUSE, 1'b0, 1'b1, 1'b0, 1'b0), S_PAUSE2, C0);
        add(sx(OP_PAUSE, 1'b0, 1'b1), S_HALTED, C0);
        while (sq.size() != 0) begin
            apply(sq.pop_front());
            e = sb.pop_front(); o = obs(); n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL pause_seq got %0d/%h want %0d/%h",
                         o.st, o.c, e.st, e.c);
            end
        end
    endtask

    task automatic test_str_timeout();
        exp_t e, o;
        add(sx(OP_STR, 1'b1, 1'b0), S_HALTED, C0);
        fet(OP_STR, 1'b0);
        add(sx(OP_STR, 1'b0, 1'b1), S_DECODE, CDEC);
        add(sx(OP_STR, 1'b0, 1'b1), S_STR1, CMEMA);
        add(sx(OP_STR, 1'b0, 1'b1), S_STR2, CSTR2);
        add(sx(OP_STR, 1'b0, 1'b1), S_STR3, CSTR3);
        add(sx(OP_STR, 1'b1, 1'b0), S_HALTED, C0);
        fet(OP_STR, 1'b0);
        add(sx(OP_STR, 1'b1, 1'b0), S_DECODE, CDEC);
        add(sx(OP_STR, 1'b1, 1'b0), S_STR1, CMEMA);
        add(sx(OP_STR, 1'b1, 1'b0), S_STR2, CSTR2);
        for (int i = 0; i < 4; i++)
            add(sx(OP_STR, 1'b1, 1'b0), S_STR3, CSTR3);
        for (int i = 0; i < 3; i++)
            add(sx(OP_STR, 1'b1, 1'(i), 1'b1, 1'b1), S_ERROR, CERR);
        while (sq.size() != 0) begin
            apply(sq.pop_front());
            e = sb.pop_front(); o = obs(); n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL str_seq got %0d/%h want %0d/%h",
                         o.st, o.c, e.st, e.c);
            end
        end
        @(negedge Clk);
        Reset = 1'b0; Run = 1'b0; #1;
        e = '0; o = obs(); n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL err_reset got %0d/%h want %0d/%h",
                     o.st, o.c, e.st, e.c);
        end
        @(negedge Clk); Reset = 1'b1;
    endtask

    initial begin
        Reset            = 1'b0;
        Run              = 1'b0;
        Continue         = 1'b0;
        IR_15_12         = 4'h0;
        IR_5             = 1'b0;
        BEN              = 1'b0;
        mem_if.Mem_Ready = 1'b0;
        test_reset();
        test_alu();
        test_ldr_wait();
        test_branch_jump();
        test_back_to_back();
        test_pause();
        test_str_timeout();
        add(sx(4'h0, 1'b0, 1'b0), S_HALTED, C0);
        while (sq.size() != 0) begin
            exp_t e, o;
            apply(sq.pop_front());
            e = sb.pop_front(); o = obs(); n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL final_idle got %0d/%h want %0d/%h",
                         o.st, o.c, e.st, e.c);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end
endmodule
